// File: rtl/control_unit_io_pkg.sv
// Shared definitions for the simple-machine control unit with memory-mapped I/O.
// Contents: FSM state encoding (doubles as the state_dbg value), opcode and SYS
// sub-op fields of cop, address-mux selects and ALU operation codes.
package ms_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StLoadA   = 4'd2,
        StLoadB   = 4'd3,
        StExec    = 4'd4,
        StBranch  = 4'd5,
        StInWait  = 4'd6,
        StOutWait = 4'd7,
        StHalt    = 4'd8
    } state_e;

    // cop[3:2]
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_MOV = 2'b10;
    localparam logic [1:0] OP_SYS = 2'b11;

    // cop[1:0] when cop[3:2] == OP_SYS
    localparam logic [1:0] SYS_BEQ  = 2'b00;
    localparam logic [1:0] SYS_IN   = 2'b01;
    localparam logic [1:0] SYS_OUT  = 2'b10;
    localparam logic [1:0] SYS_HALT = 2'b11;

    // {mx1, mx0}
    localparam logic [1:0] MX_PC   = 2'b00;
    localparam logic [1:0] MX_ZERO = 2'b01;
    localparam logic [1:0] MX_SRC  = 2'b10;
    localparam logic [1:0] MX_DST  = 2'b11;

    // {alu_op1, alu_op0}
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_PASSA = 2'b10;

    function automatic logic is_wait_state(input state_e s);
        return (s == StInWait) || (s == StOutWait);
    endfunction

endpackage

// File: rtl/control_unit_io_if.sv
// Bundle between the control unit and the datapath / I/O port.
// master: the control unit (receives cop, fz and the port handshake inputs,
//         drives every control strobe and status output).
// slave:  the datapath / port side, mirror directions.
interface control_unit_io_if;
    logic       cop_dummy_unused_guard; // never driven or read; keeps the bundle non-empty-safe
    logic [3:0] cop;
    logic       fz;
    logic       in_valid;
    logic       out_ready;
    logic       mx1;
    logic       mx0;
    logic       alu_op1;
    logic       alu_op0;
    logic       le;
    logic       pc_w;
    logic       ir_w;
    logic       a_w;
    logic       b_w;
    logic       fz_w;
    logic       mx_memio;
    logic       in_ack;
    logic       out_valid;
    logic       halted;
    logic       io_err;
    logic [3:0] state_dbg;

    modport master (
        input  cop, fz, in_valid, out_ready,
        output mx1, mx0, alu_op1, alu_op0, le, pc_w, ir_w, a_w, b_w, fz_w,
        output mx_memio, in_ack, out_valid, halted, io_err, state_dbg
    );

    modport slave (
        output cop, fz, in_valid, out_ready,
        input  mx1, mx0, alu_op1, alu_op0, le, pc_w, ir_w, a_w, b_w, fz_w,
        input  mx_memio, in_ack, out_valid, halted, io_err, state_dbg
    );
endinterface

// File: rtl/control_unit_io_io_wait_timer.sv
// Cycle counter bounding an I/O wait state.
// Ports: clk, reset (sync, active-high); clear restarts the count at 0;
// enable counts one waiting cycle; done flags the last permitted wait cycle;
// expired = done on a cycle that is still waiting (no handshake).
module io_wait_timer #(
    parameter int unsigned IO_TIMEOUT = 255,
    parameter int unsigned TO_W       = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST_COUNT = TO_W'(IO_TIMEOUT - 1);

    logic [TO_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && !done) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign done    = (count_q == LAST_COUNT);
    assign expired = enable & done;

endmodule

// File: rtl/control_unit_io.sv
// Control sequencer for the simple-machine datapath with memory-mapped I/O.
// Ports: clk, reset (sync, active-high, forces every output to 0 while high);
// bus (master side): cop/fz from the datapath, in_valid/out_ready from the
// port; drives mux selects, ALU op, RAM/register write strobes, in_ack,
// out_valid, halted, sticky io_err and state_dbg.
module control_unit_io
    import ms_ctrl_pkg::*;
#(
    parameter int unsigned IO_TIMEOUT = 255,
    parameter int unsigned TO_W       = 16
) (
    input logic               clk,
    input logic               reset,
    control_unit_io_if.master bus
);

    state_e     state_q, state_d;
    logic       io_err_q;
    logic [1:0] op, sub;
    logic [1:0] mx, alu;
    logic       le, pc_w, ir_w, a_w, b_w, fz_w, mx_memio, in_ack, out_valid, halted;
    logic       in_wait, out_wait, handshake;
    logic       tmr_done, tmr_expired;

    assign op  = bus.cop[3:2];
    assign sub = bus.cop[1:0];

    assign in_wait   = (state_q == StInWait);
    assign out_wait  = (state_q == StOutWait);
    // Handshake inputs only matter inside their own wait state.
    assign handshake = (in_wait & bus.in_valid) | (out_wait & bus.out_ready);

    // Cleared outside the wait states, so entry always starts from 0.
    io_wait_timer #(
        .IO_TIMEOUT (IO_TIMEOUT),
        .TO_W       (TO_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!is_wait_state(state_q)),
        .enable  (is_wait_state(state_q) && !handshake),
        .done    (tmr_done),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StFetch;
            io_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            io_err_q <= io_err_q | tmr_expired;
        end
    end

    always_comb begin
        state_d   = state_q;
        mx        = MX_PC;
        alu       = ALU_ADD;
        le        = 1'b0;
        pc_w      = 1'b0;
        ir_w      = 1'b0;
        a_w       = 1'b0;
        b_w       = 1'b0;
        fz_w      = 1'b0;
        mx_memio  = 1'b0;
        in_ack    = 1'b0;
        out_valid = 1'b0;
        halted    = 1'b0;

        unique case (state_q)
            StFetch: begin
                mx      = MX_PC;
                ir_w    = 1'b1;
                pc_w    = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                if (op == OP_SYS) begin
                    unique case (sub)
                        SYS_BEQ:  state_d = StBranch;
                        SYS_IN:   state_d = StInWait;
                        SYS_OUT:  state_d = StOutWait;
                        default:  state_d = StHalt;
                    endcase
                end else begin
                    state_d = StLoadA;
                end
            end
            StLoadA: begin
                mx      = MX_SRC;
                a_w     = 1'b1;
                state_d = (op == OP_MOV) ? StExec : StLoadB;
            end
            StLoadB: begin
                mx      = MX_DST;
                b_w     = 1'b1;
                state_d = StExec;
            end
            StExec: begin
                mx = MX_DST;
                unique case (op)
                    OP_ADD: begin
                        alu  = ALU_ADD;
                        le   = 1'b1;
                        fz_w = 1'b1;
                    end
                    OP_CMP: begin
                        alu  = ALU_SUB;
                        fz_w = 1'b1;
                    end
                    OP_MOV: begin
                        alu = ALU_PASSA;
                        le  = 1'b1;
                    end
                    default: ;
                endcase
                state_d = StFetch;
            end
            StBranch: begin
                // Taken branch fetches the target directly, skipping FETCH.
                if (bus.fz) begin
                    mx      = MX_DST;
                    pc_w    = 1'b1;
                    ir_w    = 1'b1;
                    state_d = StDecode;
                end else begin
                    state_d = StFetch;
                end
            end
            StInWait: begin
                mx       = MX_DST;
                mx_memio = 1'b1;
                le       = bus.in_valid;
                in_ack   = bus.in_valid;
                // A handshake on the expiry cycle still completes normally.
                if (bus.in_valid || tmr_done) begin
                    state_d = StFetch;
                end
            end
            StOutWait: begin
                mx        = MX_DST;
                out_valid = 1'b1;
                if (bus.out_ready || tmr_done) begin
                    state_d = StFetch;
                end
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        bus.mx1       = ~reset & mx[1];
        bus.mx0       = ~reset & mx[0];
        bus.alu_op1   = ~reset & alu[1];
        bus.alu_op0   = ~reset & alu[0];
        bus.le        = ~reset & le;
        bus.pc_w      = ~reset & pc_w;
        bus.ir_w      = ~reset & ir_w;
        bus.a_w       = ~reset & a_w;
        bus.b_w       = ~reset & b_w;
        bus.fz_w      = ~reset & fz_w;
        bus.mx_memio  = ~reset & mx_memio;
        bus.in_ack    = ~reset & in_ack;
        bus.out_valid = ~reset & out_valid;
        bus.halted    = ~reset & halted;
        bus.io_err    = ~reset & io_err_q;
        bus.state_dbg = reset ? 4'd0 : state_q;
    end

endmodule

// File: tb/tb_control_unit_io.sv
// Directed bench for control_unit_io: the driver pushes the expected output
// vector for every cycle into a queue; a monitor pops and compares each cycle.
module tb_control_unit_io;

    // {state, mx, alu, le, pc_w, ir_w, a_w, b_w, fz_w, mx_memio, in_ack, out_valid, halted, io_err}
    typedef logic [18:0] obs_t;

    localparam logic [10:0] F_NONE = 11'h000;
    localparam logic [10:0] F_LE   = 11'h400;
    localparam logic [10:0] F_PC   = 11'h200;
    localparam logic [10:0] F_IR   = 11'h100;
    localparam logic [10:0] F_A    = 11'h080;
    localparam logic [10:0] F_B    = 11'h040;
    localparam logic [10:0] F_FZ   = 11'h020;
    localparam logic [10:0] F_MIO  = 11'h010;
    localparam logic [10:0] F_ACK  = 11'h008;
    localparam logic [10:0] F_OV   = 11'h004;
    localparam logic [10:0] F_HLT  = 11'h002;
    localparam logic [10:0] F_ERR  = 11'h001;

    logic clk = 1'b0;
    logic reset = 1'b1;

    control_unit_io_if bus ();

    control_unit_io #(
        .IO_TIMEOUT (8),
        .TO_W       (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic step(input string nm, input logic rst, input logic [3:0] c, input logic z,
                        input logic iv, input logic ordy, input logic [3:0] st,
                        input logic [1:0] mx, input logic [1:0] alu, input logic [10:0] f);
        @(posedge clk);
        #1;
        reset         = rst;
        bus.cop       = c;
        bus.fz        = z;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        exp_q.push_back({st, mx, alu, f});
        name_q.push_back(nm);
    endtask

    // Monitor
    always @(negedge clk) begin
        obs_t  act, expv;
        string nm;
        if (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            nm   = name_q.pop_front();
            act  = {bus.state_dbg, bus.mx1, bus.mx0, bus.alu_op1, bus.alu_op0,
                    bus.le, bus.pc_w, bus.ir_w, bus.a_w, bus.b_w, bus.fz_w,
                    bus.mx_memio, bus.in_ack, bus.out_valid, bus.halted, bus.io_err};
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL %s: got st=%0d mx=%b alu=%b flags=%b, expected st=%0d mx=%b alu=%b flags=%b",
                         nm, act[18:15], act[14:13], act[12:11], act[10:0],
                         expv[18:15], expv[14:13], expv[12:11], expv[10:0]);
            end
        end
    end

    initial begin
        bus.cop = 4'b0000;
        bus.fz = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        // Reset, then park in OUT_WAIT and reset mid-wait for 3 cycles.
        step("por",        1, 4'b1110, 0, 0, 0, 0, 2'b00, 2'b00, F_NONE);
        step("fetch0",     0, 4'b1110, 0, 0, 0, 0, 2'b00, 2'b00, F_PC | F_IR);
        step("decode0",    0, 4'b1110, 0, 0, 0, 1, 2'b00, 2'b00, F_NONE);
        step("outwait0",   0, 4'b1110, 0, 0, 0, 7, 2'b11, 2'b00, F_OV);
        for (int i = 0; i < 3; i++)
            step("rst_wait", 1, 4'b1110, 0, 0, 0, 0, 2'b00, 2'b00, F_NONE);
        step("rel_fetch",  0, 4'b0011, 0, 0, 0, 0, 2'b00, 2'b00, F_PC | F_IR);

        // ADD (out_ready/in_valid asserted to show they are ignored)
        step("add_dec",    0, 4'b0011, 0, 1, 1, 1, 2'b00, 2'b00, F_NONE);
        step("add_lda",    0, 4'b0011, 0, 1, 1, 2, 2'b10, 2'b00, F_A);
        step("add_ldb",    0, 4'b0011, 0, 0, 0, 3, 2'b11, 2'b00, F_B);
        step("add_exec",   0, 4'b0011, 0, 0, 0, 4, 2'b11, 2'b00, F_LE | F_FZ);
        step("cmp_fetch",  0, 4'b0101, 0, 0, 0, 0, 2'b00, 2'b00, F_PC | F_IR);
        // CMP
        step("cmp_dec",    0, 4'b0101, 0, 0, 0, 1, 2'b00, 2'b00, F_NONE);
        step("cmp_lda",    0, 4'b0101, 0, 0, 0, 2, 2'b10, 2'b00, F_A);
        step("cmp_ldb",    0, 4'b0101, 0, 0, 0, 3, 2'b11, 2'b00, F_B);
        step("cmp_exec",   0, 4'b0101, 0, 0, 0, 4, 2'b11, 2'b01, F_FZ);
        step("mov_fetch",  0, 4'b1000, 0, 0, 0, 0, 2'b00, 2'b00, F_PC | F_IR);
        // MOV skips LOAD_B
        step("mov_dec",    0, 4'b1000, 0, 0, 0, 1, 2'b00, 2'b00, F_NONE);
        step("mov_lda",    0, 4'b1000, 0, 0, 0, 2, 2'b10, 2'b00, F_A);
        step("mov_exec",   0, 4'b1000, 0, 0, 0, 4, 2'b11, 2'b10, F_LE);
        step("beq_fetch",  0, 4'b1100, 0, 0, 0, 0, 2'b00, 2'b00, F_PC | F_IR);
        // BEQ taken then not taken
        step("beq_dec",    0, 4'b1100, 0, 0, 0, 1, 2'b00, 2'b00, F_NONE);
        step("beq_taken",  0, 4'b1100, 1, 0, 0, 5, 2'b11, 2'b00, F_PC | F_IR);
        step("beq_dec2",   0, 4'b1100, 0, 0, 0, 1, 2'b00, 2'b00, F_NONE);
        step("beq_ntaken", 0, 4'b1100, 0, 0, 0, 5, 2'b00, 2'b00, F_NONE);
        step("in_fetch",   0, 4'b1101, 0, 0, 0, 0, 2'b00, 2'b00, F_PC | F_IR);
        // IN with in_valid on the 4th wait cycle
        step("in_dec",     0, 4'b1101, 0, 0, 0, 1, 2'b00, 2'b00, F_NONE);
        for (int i = 0; i < 3; i++)
            step("in_wait",  0, 4'b1101, 0, 0, 1, 6, 2'b11, 2'b00, F_MIO);
        step("in_hs",      0, 4'b1101, 0, 1, 0, 6, 2'b11, 2'b00, F_MIO | F_LE | F_ACK);
        step("out_fetch",  0, 4'b1110, 0, 0, 0, 0, 2'b00, 2'b00, F_PC | F_IR);
        // OUT timeout after 8 wait cycles; in_valid in OUT_WAIT is ignored
        step("out_dec",    0, 4'b1110, 0, 0, 0, 1, 2'b00, 2'b00, F_NONE);
        for (int i = 0; i < 8; i++)
            step("out_to",   0, 4'b1110, 0, (i == 3), 0, 7, 2'b11, 2'b00, F_OV);
        step("to_fetch",   0, 4'b0011, 0, 0, 0, 0, 2'b00, 2'b00, F_PC | F_IR | F_ERR);
        step("err_dec",    0, 4'b0011, 0, 0, 0, 1, 2'b00, 2'b00, F_ERR);
        step("err_lda",    0, 4'b0011, 0, 0, 0, 2, 2'b10, 2'b00, F_A | F_ERR);
        step("err_ldb",    0, 4'b0011, 0, 0, 0, 3, 2'b11, 2'b00, F_B | F_ERR);
        step("err_exec",   0, 4'b0011, 0, 0, 0, 4, 2'b11, 2'b00, F_LE | F_FZ | F_ERR);
        step("err_fetch",  0, 4'b1110, 0, 0, 0, 0, 2'b00, 2'b00, F_PC | F_IR | F_ERR);
        // Reset clears io_err; OUT completes on the expiry cycle
        step("rst_err",    1, 4'b1110, 0, 0, 0, 0, 2'b00, 2'b00, F_NONE);
        step("out2_fetch", 0, 4'b1110, 0, 0, 0, 0, 2'b00, 2'b00, F_PC | F_IR);
        step("out2_dec",   0, 4'b1110, 0, 0, 0, 1, 2'b00, 2'b00, F_NONE);
        for (int i = 0; i < 8; i++)
            step("out2_wait", 0, 4'b1110, 0, 0, (i == 7), 7, 2'b11, 2'b00, F_OV);
        step("hlt_fetch",  0, 4'b1111, 0, 0, 0, 0, 2'b00, 2'b00, F_PC | F_IR);
        // HALT holds until reset
        step("hlt_dec",    0, 4'b1111, 0, 0, 0, 1, 2'b00, 2'b00, F_NONE);
        for (int i = 0; i < 5; i++)
            step("halt",     0, 4'b1111, 1, i[0], ~i[0], 8, 2'b00, 2'b00, F_HLT);
        step("rst_halt",   1, 4'b1111, 0, 0, 0, 0, 2'b00, 2'b00, F_NONE);
        step("post_halt",  0, 4'b0011, 0, 0, 0, 0, 2'b00, 2'b00, F_PC | F_IR);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
